vga_scan_ctrl: RTL
==================

Name: vga_scan_ctrl

Overview:
VGA 640x480@60 timing generator and pixel-output stage: the coordinate-driving end of the tile/sprite renderer interface.
- Produces Q_X/Q_Y for the renderers (e.g. Rom_tile) and consumes their R/G/B/visible response.
- Registers the final colour and sync signals to the DAC/pins, aligned for a configurable renderer latency.
- Sits between the pixel-clock-enable source and the board VGA connector.

Parameters:
H_ACTIVE, 640, visible pixels per line
H_FP, 16, horizontal front porch (pixels)
H_SYNC, 96, hsync pulse width (pixels)
H_BP, 48, horizontal back porch (pixels)
V_ACTIVE, 480, visible lines
V_FP, 10, vertical front porch (lines)
V_SYNC, 2, vsync pulse width (lines)
V_BP, 33, vertical back porch (lines)
PIPE_LAT, 0, pix_ce ticks from Q_X/Q_Y change to valid R/G/B/visible (0 = combinational renderer)
BG_COLOR, 24'h000040, colour shown in the active area where visible=0

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
pix_ce  in  1  pixel-rate clock enable (one clk pulse per pixel)
Q_X  out  10  current horizontal counter to renderer
Q_Y  out  10  current vertical counter to renderer
R  in  8  renderer red
G  in  8  renderer green
B  in  8  renderer blue
visible  in  1  renderer pixel-valid
vga_r  out  8  registered red to DAC
vga_g  out  8  registered green to DAC
vga_b  out  8  registered blue to DAC
vga_hs  out  1  hsync, active low
vga_vs  out  1  vsync, active low
vga_blank_n  out  1  high in the active area
frame_start  out  1  one-clk pulse at start of frame

Behaviour:
- Reset: one clk, synchronous, active-low.
  - Reset values: h_cnt=0, v_cnt=0, vga_r/g/b=0, vga_hs=1, vga_vs=1, vga_blank_n=0, frame_start=0.
  - All delay-line stages are cleared to "inactive, syncs high".
  - Reset mid-frame aborts the frame. The first pix_ce after release presents Q_X=0, Q_Y=0.
- Counters:
  - H_TOT = H_ACTIVE+H_FP+H_SYNC+H_BP (800). V_TOT = V_ACTIVE+V_FP+V_SYNC+V_BP (525).
  - h_cnt advances only on pix_ce: at H_TOT-1 it wraps to 0 and v_cnt advances.
  - v_cnt wraps V_TOT-1 to 0 on the same tick as h_cnt wraps.
  - With pix_ce=0 every register holds.
- Q_X=h_cnt and Q_Y=v_cnt, driven directly from the counter registers, both 10 bits. Values in the blanking interval (≥640 / ≥480) are still driven.
- Decode from the current counters:
  - active = (h_cnt<H_ACTIVE) && (v_cnt<V_ACTIVE)
  - hs_raw low for h_cnt in [H_ACTIVE+H_FP, H_ACTIVE+H_FP+H_SYNC-1] (656..751)
  - vs_raw low for v_cnt in [V_ACTIVE+V_FP, V_ACTIVE+V_FP+V_SYNC-1] (490..491)
- Alignment:
  - active, hs_raw and vs_raw pass through a PIPE_LAT-stage delay line advanced on pix_ce.
  - On each pix_ce the output registers capture the delayed values.
  - Colour mux:
    - delayed active=0: output 0
    - delayed active=1 and visible=1: output {R,G,B}
    - delayed active=1 and visible=0: output BG_COLOR
  - Total latency from a counter value to the pins is PIPE_LAT+1 pix_ce ticks, identical for colour, sync and blank_n.
- frame_start:
  - Registered and high for exactly one clk cycle.
  - Asserted in the cycle after the pix_ce tick on which the counters wrap to (0,0).
  - Never asserted for the first (0,0) after reset.
- Inputs are not checked for X. visible is ignored outside the active area.

Decomposition:
- Package vga_timing_pkg:
  - 640x480 timing localparams and H_TOT/V_TOT.
  - typedef rgb_t: packed struct of 3x8 bits.
  - BG_COLOR default.
- Sub-module vga_delay_line (width W, depth D, enable; D=0 is a wire), instantiated once for {active, hs_raw, vs_raw}.

Test Plan:
- Reset: hold rst_n=0 for 5 clk with pix_ce toggling -> all outputs at reset values. First pix_ce after release gives Q_X=0, Q_Y=0.
- Hsync: pix_ce every 2nd clk, PIPE_LAT=0 -> vga_hs low for exactly 96 ticks starting 657 ticks after line start. Line period 800 ticks; vga_blank_n high 640 ticks per active line.
- Vsync/frame: run one full frame -> vga_vs low while lines 490-491 reach the pins. frame_start pulses once per 420000 ticks, one clk wide.
- Renderer path: Rom_tile stub with visible=1 only for Q_X 420..439, Q_Y 160..179, colour 8'hFF/8'h80/8'h00:
  - pixel (420,160) -> FF/80/00 one tick later
  - pixel (419,160) -> BG_COLOR
  - pixel (700,160) -> 0/0/0
- Latency: PIPE_LAT=2 with a 2-tick-delayed renderer stub -> first visible pixel and hs edge both appear 3 ticks after the counter reaches 420 and 656 respectively.
- Mid-frame reset and gating: assert rst_n=0 at Q_Y=200 -> counters return to 0, no frame_start. Holding pix_ce=0 for 10 clk -> no output change.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// -----------------------------------------------------------------------------
// vga_timing_pkg
// Shared timing constants and types for the VGA scan controller.
//   - Default 640x480@60 timing (pixels / lines), with line and frame totals
//   - rgb_t: packed 24-bit colour, red in the top byte
//   - Default background colour for active pixels with no renderer hit
// -----------------------------------------------------------------------------
package vga_timing_pkg;

    // Counter width used for Q_X/Q_Y; wide enough for both 800 and 525.
    localparam int CNT_W = 10;

    localparam int DEF_H_ACTIVE = 640;
    localparam int DEF_H_FP     = 16;
    localparam int DEF_H_SYNC   = 96;
    localparam int DEF_H_BP     = 48;
    localparam int DEF_V_ACTIVE = 480;
    localparam int DEF_V_FP     = 10;
    localparam int DEF_V_SYNC   = 2;
    localparam int DEF_V_BP     = 33;

    localparam int DEF_H_TOT = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
    localparam int DEF_V_TOT = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;

    typedef struct packed {
        logic [7:0] r;
        logic [7:0] g;
        logic [7:0] b;
    } rgb_t;

    localparam rgb_t DEF_BG_COLOR = 24'h000040;

endpackage

// File: rtl/vga_delay_line.sv
// -----------------------------------------------------------------------------
// vga_delay_line
// D-stage shift register advanced only when en is high. D=0 degenerates to a
// plain wire so a zero-latency renderer adds no register stage.
// Ports:
//   clk    in   system clock
//   rst_n  in   synchronous active-low reset (stages load RST_VAL)
//   en     in   advance enable (pixel clock enable)
//   din    in   W-bit input
//   dout   out  W-bit input delayed by D enabled cycles
// -----------------------------------------------------------------------------
module vga_delay_line #(
    parameter int           W       = 1,
    parameter int           D       = 0,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         en,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout
);

    generate
        if (D == 0) begin : g_wire
            // Clock, reset and enable are not needed when there is no stage.
            logic unused_ctrl;
            assign unused_ctrl = &{1'b0, clk, rst_n, en};
            assign dout = din;
        end else begin : g_pipe
            logic [W-1:0] stage [D];

            // NOTE: every stage is reset, not just the output, so no stale
            // sync/active value from before reset can ever reach the pins.
            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    for (int i = 0; i < D; i++) stage[i] <= RST_VAL;
                end else if (en) begin
                    stage[0] <= din;
                    for (int i = 1; i < D; i++) stage[i] <= stage[i-1];
                end
            end

            assign dout = stage[D-1];
        end
    endgenerate

endmodule

// File: rtl/vga_scan_ctrl.sv
// -----------------------------------------------------------------------------
// vga_scan_ctrl
// VGA timing generator and registered pixel output stage. Drives the current
// scan position to the renderers and registers their colour response together
// with sync/blank, all delayed by the same PIPE_LAT+1 pixel ticks.
// Ports:
//   clk          in   system clock
//   rst_n        in   synchronous active-low reset
//   pix_ce       in   pixel clock enable, one clk pulse per pixel
//   Q_X, Q_Y     out  horizontal / vertical counters to the renderer
//   R, G, B      in   renderer colour (valid PIPE_LAT ticks after Q_X/Q_Y)
//   visible      in   renderer hit flag (ignored outside the active area)
//   vga_r/g/b    out  registered colour to the DAC
//   vga_hs/vs    out  registered syncs, active low
//   vga_blank_n  out  high while an active-area pixel is on the pins
//   frame_start  out  one-clk pulse after the counters wrap to (0,0)
// -----------------------------------------------------------------------------
module vga_scan_ctrl
    import vga_timing_pkg::*;
#(
    parameter int   H_ACTIVE = DEF_H_ACTIVE,
    parameter int   H_FP     = DEF_H_FP,
    parameter int   H_SYNC   = DEF_H_SYNC,
    parameter int   H_BP     = DEF_H_BP,
    parameter int   V_ACTIVE = DEF_V_ACTIVE,
    parameter int   V_FP     = DEF_V_FP,
    parameter int   V_SYNC   = DEF_V_SYNC,
    parameter int   V_BP     = DEF_V_BP,
    parameter int   PIPE_LAT = 0,
    parameter rgb_t BG_COLOR = DEF_BG_COLOR
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_ce,
    output logic [CNT_W-1:0] Q_X,
    output logic [CNT_W-1:0] Q_Y,
    input  logic [7:0]       R,
    input  logic [7:0]       G,
    input  logic [7:0]       B,
    input  logic             visible,
    output logic [7:0]       vga_r,
    output logic [7:0]       vga_g,
    output logic [7:0]       vga_b,
    output logic             vga_hs,
    output logic             vga_vs,
    output logic             vga_blank_n,
    output logic             frame_start
);

    localparam int H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [CNT_W-1:0] H_LAST   = CNT_W'(H_TOT - 1);
    localparam logic [CNT_W-1:0] V_LAST   = CNT_W'(V_TOT - 1);
    localparam logic [CNT_W-1:0] H_ACT    = CNT_W'(H_ACTIVE);
    localparam logic [CNT_W-1:0] V_ACT    = CNT_W'(V_ACTIVE);
    localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(H_ACTIVE + H_FP);
    localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(V_ACTIVE + V_FP);
    localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(V_ACTIVE + V_FP + V_SYNC - 1);

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_wrap;
    logic             v_wrap;

    assign h_wrap = (h_cnt == H_LAST);
    assign v_wrap = (v_cnt == V_LAST);

    // NOTE: state registers use non-blocking assignments so every flop samples
    // the pre-edge values of the others, independent of statement order.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            h_cnt <= '0;
            v_cnt <= '0;
        end else if (pix_ce) begin
            if (h_wrap) begin
                h_cnt <= '0;
                v_cnt <= v_wrap ? '0 : v_cnt + CNT_W'(1);
            end else begin
                h_cnt <= h_cnt + CNT_W'(1);
            end
        end
    end

    assign Q_X = h_cnt;
    assign Q_Y = v_cnt;

    // Position decode for the current counter value.
    logic active;
    logic hs_raw;
    logic vs_raw;

    assign active = (h_cnt < H_ACT) && (v_cnt < V_ACT);
    assign hs_raw = !((h_cnt >= HS_FIRST) && (h_cnt <= HS_LAST));
    assign vs_raw = !((v_cnt >= VS_FIRST) && (v_cnt <= VS_LAST));

    // Delay decode by the renderer latency so it lines up with R/G/B/visible.
    // Reset value is "inactive, syncs high".
    logic d_active;
    logic d_hs;
    logic d_vs;

    vga_delay_line #(
        .W       (3),
        .D       (PIPE_LAT),
        .RST_VAL (3'b011)
    ) u_align (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (pix_ce),
        .din   ({active, hs_raw, vs_raw}),
        .dout  ({d_active, d_hs, d_vs})
    );

    // NOTE: the default assignment first keeps this combinational block free
    // of inferred latches on any path through the ifs.
    rgb_t pix_rgb;
    always_comb begin
        pix_rgb = '0;
        if (d_active) begin
            pix_rgb = visible ? rgb_t'{r: R, g: G, b: B} : BG_COLOR;
        end
    end

    rgb_t out_rgb;
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            out_rgb     <= '0;
            vga_hs      <= 1'b1;
            vga_vs      <= 1'b1;
            vga_blank_n <= 1'b0;
        end else if (pix_ce) begin
            out_rgb     <= pix_rgb;
            vga_hs      <= d_hs;
            vga_vs      <= d_vs;
            vga_blank_n <= d_active;
        end
    end

    assign vga_r = out_rgb.r;
    assign vga_g = out_rgb.g;
    assign vga_b = out_rgb.b;

    // Updated every clk (not gated by pix_ce) so the pulse is exactly one clk
    // wide. Only a real wrap sets it, so the (0,0) after reset never does.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            frame_start <= 1'b0;
        end else begin
            frame_start <= pix_ce && h_wrap && v_wrap;
        end
    end

endmodule
